acq_sequencer: RTL and testbench
================================

// Module: acq_sequencer
// PURPOSE
//  Acquisition controller in front of the trigger averager. Arms on start and gates exactly
//  SAMPLES_PER_SHOT ADC beats per trigger edge into the averager's input stream, with tlast.
//  Counts shots up to the configured average count, then waits for the averager's result burst.
//  Raises a one-cycle done pulse. ADC data outside a capture window is discarded.
// PARAMETERS
//  DATA_WIDTH        32       ADC/averager AXIS tdata width
//  SAMPLES_PER_SHOT  1024     beats forwarded per trigger (>=2)
//  TIMEOUT_CYCLES    1000000  ARMED watchdog limit (used only with ACQ_SEQ_TIMEOUT_EN)
// PORTS
//  s00_axis_aclk    in   1           single clock for all logic
//  s00_axis_areset  in   1           asynchronous, active-high reset
//  start            in   1           1-cycle pulse: latch cfg, begin run (IDLE only)
//  abort            in   1           level/pulse: terminate run, return to IDLE
//  trig_in          in   1           trigger, already synchronised to s00_axis_aclk
//  cfg_num_avg      in   16          shots per run; 0 treated as 1
//  cfg_holdoff      in   16          idle cycles after each shot before re-arming
//  s00_axis_tvalid  in   1           ADC stream valid
//  s00_axis_tdata   in   DATA_WIDTH  ADC sample
//  s00_axis_tready  out  1           ADC stream ready
//  m00_axis_tready  in   1           averager input ready
//  m00_axis_tvalid  out  1           averager input valid
//  m00_axis_tdata   out  DATA_WIDTH  averager input data
//  m00_axis_tlast   out  1           last beat of a shot
//  avg_result_last  in   1           1-cycle pulse: averager emitted final result beat
//  busy             out  1           high in every state except IDLE
//  done             out  1           1-cycle pulse at run completion
//  shot_count       out  16          shots completed in current/last run
//  trig_missed      out  8           triggers ignored during CAPTURE/HOLDOFF (saturating)
//  timeout_err      out  1           sticky watchdog flag; cleared on start
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, m00 valid/last, timeout_err=0; shot_count, trig_missed=0;
//   trig edge register=0.
//  States: IDLE -> ARMED -> CAPTURE -> (HOLDOFF -> ARMED)* -> DRAIN -> DONE -> IDLE.
//  IDLE: on start, latch cfg_num_avg/cfg_holdoff. Clear shot_count, trig_missed, timeout_err.
//   Go to ARMED. start in any other state is ignored.
//  ARMED: trigger = trig_in & ~trig_in_d. trig_in_d is registered every cycle, so a level that
//   is already high when arming does not fire. On a trigger, go to CAPTURE with beat_cnt=0.
//  CAPTURE: zero-latency combinational passthrough.
//   m00_tvalid=s00_tvalid, m00_tdata=s00_tdata, s00_tready=m00_tready.
//   beat_cnt advances on the m00 handshake.
//   m00_tlast=1 when beat_cnt==SAMPLES_PER_SHOT-1.
//   On that handshake: shot_count+1; if the new count equals num_avg go to DRAIN. Otherwise go
//   to HOLDOFF, or straight to ARMED if holdoff==0.
//  HOLDOFF: count cfg_holdoff cycles, then go to ARMED.
//  Outside CAPTURE: s00_tready=1 (samples dropped), m00_tvalid=0, m00_tlast=0.
//  Rising trig edges in CAPTURE/HOLDOFF increment trig_missed, saturating at 255. No queueing.
//  DRAIN: wait for avg_result_last, then go to DONE. A pulse arriving before DRAIN is ignored.
//  DONE: done=1 for exactly one cycle, then IDLE. shot_count holds until the next start.
//  abort (any state, priority over all else): IDLE next cycle.
//   A burst cut mid-shot ends without tlast; the system must reset the averager.
//   done is not pulsed on abort.
//  start and abort in the same cycle: abort wins.
//  Counters are 16-bit. num_avg is at most 65535, so no wrap is possible.
// CONFIGURATION
//  ACQ_SEQ_TIMEOUT_EN defined:
//   32-bit watchdog runs in ARMED and restarts on every entry to ARMED.
//   On reaching TIMEOUT_CYCLES without a trigger: timeout_err<=1 (sticky) and state -> IDLE.
//   No done pulse is issued.
//  Not defined: no watchdog; timeout_err tied 0; ARMED waits indefinitely.
// TESTING
//  1 Reset mid-CAPTURE -> next cycle IDLE, m00_tvalid=0, busy=0, shot_count=0.
//  2 start num_avg=3, holdoff=4, 3 triggers, ADC always valid ->
//    3x1024 beats, tlast on beats 1023/2047/3071. Then shot_count=3, DRAIN.
//    avg_result_last then gives done 1 cycle.
//  3 m00_tready toggled 50% during CAPTURE -> no beat lost/duplicated; tlast only on 1024th
//    handshake.
//  4 trig_in high before start and held -> no capture until low then high.
//    Two extra edges during HOLDOFF -> trig_missed=2.
//  5 abort at beat 500 of shot 2 -> IDLE next cycle, no tlast, no done.
//    Then start with num_avg=0 -> exactly 1 shot, then done.
//  6 (ACQ_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100) arm, no trigger ->
//    timeout_err=1 after 100 cycles, IDLE, busy=0; next start clears it.

Source files
------------

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arms on start, gates SAMPLES_PER_SHOT beats per trigger.
// Optional ARMED watchdog enabled by defining ACQ_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module acq_sequencer #(
    parameter int DATA_WIDTH       = 32,
    parameter int SAMPLES_PER_SHOT = 1024,
    parameter int TIMEOUT_CYCLES   = 1000000
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_areset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  trig_in,
    input  logic [15:0]           cfg_num_avg,
    input  logic [15:0]           cfg_holdoff,
    input  logic                  s00_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
    output logic                  s00_axis_tready,
    input  logic                  m00_axis_tready,
    output logic                  m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m00_axis_tdata,
    output logic                  m00_axis_tlast,
    input  logic                  avg_result_last,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           shot_count,
    output logic [7:0]            trig_missed,
    output logic                  timeout_err
);
    localparam int BW = $clog2(SAMPLES_PER_SHOT);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_CAPTURE, S_HOLDOFF, S_DRAIN, S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic          trig_q;
    logic [15:0]   num_avg_q, num_avg_d;
    logic [15:0]   holdoff_q, holdoff_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [15:0]   hold_q, hold_d;
    logic [15:0]   shot_q, shot_d;
    logic [7:0]    missed_q, missed_d;
    logic          trig_edge;
    logic          beat_last;
    logic          hs;
`ifdef ACQ_SEQ_TIMEOUT_EN
    logic [31:0]   wd_q, wd_d;
    logic          terr_q, terr_d;
`endif

    // State and counter registers; trigger history sampled every cycle
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state_q   <= S_IDLE;
            trig_q    <= 1'b0;
            num_avg_q <= 16'd0;
            holdoff_q <= 16'd0;
            beat_q    <= '0;
            hold_q    <= 16'd0;
            shot_q    <= 16'd0;
            missed_q  <= 8'd0;
`ifdef ACQ_SEQ_TIMEOUT_EN
            wd_q      <= 32'd0;
            terr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            trig_q    <= trig_in;
            num_avg_q <= num_avg_d;
            holdoff_q <= holdoff_d;
            beat_q    <= beat_d;
            hold_q    <= hold_d;
            shot_q    <= shot_d;
            missed_q  <= missed_d;
`ifdef ACQ_SEQ_TIMEOUT_EN
            wd_q      <= wd_d;
            terr_q    <= terr_d;
`endif
        end
    end

    assign trig_edge = trig_in & ~trig_q;
    assign beat_last = (beat_q == BW'(SAMPLES_PER_SHOT - 1));
    assign hs        = s00_axis_tvalid & m00_axis_tready;

    // Next-state logic, stream gating and counter updates
    always_comb begin
        state_d         = state_q;
        num_avg_d       = num_avg_q;
        holdoff_d       = holdoff_q;
        beat_d          = beat_q;
        hold_d          = hold_q;
        shot_d          = shot_q;
        missed_d        = missed_q;
`ifdef ACQ_SEQ_TIMEOUT_EN
        wd_d            = wd_q;
        terr_d          = terr_q;
`endif
        s00_axis_tready = 1'b1;
        m00_axis_tvalid = 1'b0;
        m00_axis_tdata  = s00_axis_tdata;
        m00_axis_tlast  = 1'b0;

        if ((state_q == S_CAPTURE || state_q == S_HOLDOFF) &&
            trig_edge && missed_q != 8'hFF) begin
            missed_d = missed_q + 8'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_avg_d = (cfg_num_avg == 16'd0) ? 16'd1 : cfg_num_avg;
                    holdoff_d = cfg_holdoff;
                    shot_d    = 16'd0;
                    missed_d  = 8'd0;
`ifdef ACQ_SEQ_TIMEOUT_EN
                    terr_d    = 1'b0;
                    wd_d      = 32'd0;
`endif
                    state_d   = S_ARMED;
                end
            end
            S_ARMED: begin
`ifdef ACQ_SEQ_TIMEOUT_EN
                wd_d = wd_q + 32'd1;
`endif
                if (trig_edge) begin
                    beat_d  = '0;
                    state_d = S_CAPTURE;
                end
`ifdef ACQ_SEQ_TIMEOUT_EN
                else if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            S_CAPTURE: begin
                s00_axis_tready = m00_axis_tready;
                m00_axis_tvalid = s00_axis_tvalid;
                m00_axis_tlast  = beat_last;
                if (hs) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_last) begin
                        beat_d = '0;
                        shot_d = shot_q + 16'd1;
                        if (shot_q + 16'd1 == num_avg_q) begin
                            state_d = S_DRAIN;
                        end else if (holdoff_q == 16'd0) begin
`ifdef ACQ_SEQ_TIMEOUT_EN
                            wd_d    = 32'd0;
`endif
                            state_d = S_ARMED;
                        end else begin
                            hold_d  = 16'd0;
                            state_d = S_HOLDOFF;
                        end
                    end
                end
            end
            S_HOLDOFF: begin
                hold_d = hold_q + 16'd1;
                if (hold_q == holdoff_q - 16'd1) begin
`ifdef ACQ_SEQ_TIMEOUT_EN
                    wd_d    = 32'd0;
`endif
                    state_d = S_ARMED;
                end
            end
            S_DRAIN: begin
                if (avg_result_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign shot_count  = shot_q;
    assign trig_missed = missed_q;
`ifdef ACQ_SEQ_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer: stimulus queues expected beats,
// a negedge monitor pops and compares them on every m00 handshake.
`timescale 1ns/1ps
module tb_acq_sequencer;
    localparam int DW  = 32;
    localparam int SPS = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          trig = 1'b0;
    logic [15:0]   cfg_num_avg = 16'd0;
    logic [15:0]   cfg_holdoff = 16'd0;
    logic          s_tvalid = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tready;
    logic          m_tready = 1'b1;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          avg_last = 1'b0;
    logic          busy;
    logic          done;
    logic [15:0]   shot_count;
    logic [7:0]    trig_missed;
    logic          timeout_err;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   junk = 0;

    always #5 clk = ~clk;

    acq_sequencer #(
        .DATA_WIDTH(DW),
        .SAMPLES_PER_SHOT(SPS),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_areset(rst),
        .start(start),
        .abort(abort),
        .trig_in(trig),
        .cfg_num_avg(cfg_num_avg),
        .cfg_holdoff(cfg_holdoff),
        .s00_axis_tvalid(s_tvalid),
        .s00_axis_tdata(s_tdata),
        .s00_axis_tready(s_tready),
        .m00_axis_tready(m_tready),
        .m00_axis_tvalid(m_tvalid),
        .m00_axis_tdata(m_tdata),
        .m00_axis_tlast(m_tlast),
        .avg_result_last(avg_last),
        .busy(busy),
        .done(done),
        .shot_count(shot_count),
        .trig_missed(trig_missed),
        .timeout_err(timeout_err)
    );

    // Monitor: compare every forwarded beat against the scoreboard
    always @(negedge clk) begin
        if (!rst && done) done_cnt++;
        if (!rst && m_tvalid && m_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat: unexpected data=%h last=%b", m_tdata, m_tlast);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (m_tdata !== e.d || m_tlast !== e.l) begin
                    errors++;
                    $display("FAIL beat: got data=%h last=%b, want data=%h last=%b",
                             m_tdata, m_tlast, e.d, e.l);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'hDEAD_0000 | junk;
            junk++;
            m_tready = 1'b1;
            step();
        end
    endtask

    task automatic do_start(input logic [15:0] na, input logic [15:0] ho);
        cfg_num_avg = na;
        cfg_holdoff = ho;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic fire();
        s_tvalid = 1'b1;
        s_tdata  = 32'hDEAD_FFFF;
        trig = 1'b0;
        step();
        trig = 1'b1;
        step();
        trig = 1'b0;
    endtask

    task automatic pulse_avg();
        avg_last = 1'b1;
        step();
        avg_last = 1'b0;
    endtask

    // Present tagged beats; advance only on a source-side handshake
    task automatic feed(input logic [7:0] tag, input int nb, input bit tog);
        int  b = 0;
        int  cyc = 0;
        bit  hs;
        bit  pushed = 1'b0;
        exp_t e;
        while (b < nb && cyc < nb * 4 + 16) begin
            s_tdata  = {tag, 24'(b)};
            s_tvalid = 1'b1;
            m_tready = tog ? ((cyc % 4) < 2) : 1'b1;
            if (!pushed) begin
                e.d = s_tdata;
                e.l = (b == SPS - 1);
                exp_q.push_back(e);
                pushed = 1'b1;
            end
            @(negedge clk);
            hs = s_tvalid && s_tready;
            step();
            cyc++;
            if (hs) begin
                b++;
                pushed = 1'b0;
            end
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        checks++;
        if (b != nb) begin
            errors++;
            $display("FAIL feed_tag%0h: got %0d beats, want %0d", tag, b, nb);
        end
    endtask

    initial begin
        int d0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_shots", shot_count, 0);
        chk("rst_missed", trig_missed, 0);
        chk("rst_terr", timeout_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();

        // 1: async reset in the middle of a capture
        do_start(16'd2, 16'd0);
        fire();
        feed(8'h10, 10, 1'b0);
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("t1_tvalid", m_tvalid, 0);
        chk("t1_busy", busy, 0);
        chk("t1_shots", shot_count, 0);
        step();
        rst = 1'b0;
        idle(2);

        // 2: three shots with holdoff 4, early averager pulse ignored
        d0 = done_cnt;
        do_start(16'd3, 16'd4);
        for (int s = 0; s < 3; s++) begin
            fire();
            feed(8'hA0 + 8'(s), SPS, 1'b0);
            chk("t2_shots", shot_count, s + 1);
            if (s == 0) begin
                m_tready = 1'b0;
                #1;
                chk("t2_drop_rdy", s_tready, 1);
                m_tready = 1'b1;
                pulse_avg();
            end
            if (s < 2) idle(6);
        end
        idle(5);
        chk("t2_drain_busy", busy, 1);
        chk("t2_no_early_done", done_cnt, d0);
        pulse_avg();
        idle(4);
        chk("t2_done_once", done_cnt, d0 + 1);
        chk("t2_idle", busy, 0);
        chk("t2_shots_hold", shot_count, 3);

        // 3+4: trigger held high at arming, missed edges, ready toggling
        d0 = done_cnt;
        trig = 1'b1;
        do_start(16'd2, 16'd12);
        idle(6);
        chk("t4_armed_wait", busy, 1);
        chk("t4_no_capture", exp_q.size(), 0);
        fire();
        feed(8'hB0, SPS, 1'b1);
        trig = 1'b1; idle(1);
        trig = 1'b0; idle(1);
        trig = 1'b1; idle(1);
        trig = 1'b0; idle(1);
        chk("t4_missed", trig_missed, 2);
        idle(10);
        fire();
        feed(8'hB1, SPS, 1'b1);
        chk("t4_shots", shot_count, 2);
        pulse_avg();
        idle(4);
        chk("t4_done", done_cnt, d0 + 1);
        chk("t4_missed_end", trig_missed, 2);

        // 5: abort mid-shot, then num_avg=0 runs exactly one shot
        d0 = done_cnt;
        do_start(16'd3, 16'd2);
        fire();
        feed(8'hC0, SPS, 1'b0);
        idle(4);
        fire();
        feed(8'hC1, 500, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_idle", busy, 0);
        idle(4);
        chk("t5_no_done", done_cnt, d0);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("t5_abort_wins", busy, 0);
        do_start(16'd0, 16'd0);
        fire();
        feed(8'hD0, SPS, 1'b0);
        idle(2);
        chk("t5_one_shot", shot_count, 1);
        chk("t5_drain", busy, 1);
        pulse_avg();
        idle(4);
        chk("t5_done", done_cnt, d0 + 1);

`ifdef ACQ_SEQ_TIMEOUT_EN
        // 6: watchdog expiry in ARMED
        d0 = done_cnt;
        trig = 1'b0;
        do_start(16'd1, 16'd0);
        repeat (98) step();
        chk("t6_still_armed", busy, 1);
        chk("t6_no_err_yet", timeout_err, 0);
        repeat (2) step();
        chk("t6_idle", busy, 0);
        chk("t6_err", timeout_err, 1);
        chk("t6_no_done", done_cnt, d0);
        do_start(16'd1, 16'd0);
        chk("t6_cleared", timeout_err, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
`else
        chk("t6_terr_tied", timeout_err, 0);
`endif

        idle(2);
        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "bench timeout");
    end

endmodule
